// File: rtl/nios2_qsys_ram_arbiter_if.sv
// rtl/nios2_qsys_ram_arbiter_if.sv - Avalon-MM pipelined master port bundle for the RAM arbiter
`timescale 1ns/1ps
interface nios2_qsys_ram_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic [31:0]       readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_qsys_ram_arbiter.sv
// rtl/nios2_qsys_ram_arbiter.sv - two-master round-robin arbiter with burst cap for the single-port RAM
// Optional address bounds checking with err_oob output: RAM_ARB_BOUNDS_CHECK_EN
`timescale 1ns/1ps
module nios2_qsys_ram_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DEPTH     = 2560,
    parameter int MAX_BURST = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    nios2_qsys_ram_arbiter_if.slave     m0,
    nios2_qsys_ram_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0]           ram_address,
    output logic [3:0]                  ram_byteenable,
    output logic                        ram_chipselect,
    output logic                        ram_write,
    output logic [31:0]                 ram_writedata,
    output logic                        ram_clken,
    input  logic [31:0]                 ram_readdata
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    ,
    output logic                        err_oob
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0]        BURST_LAST = 4'(MAX_BURST - 1);
    localparam logic [ADDR_W:0]   DEPTH_W    = (ADDR_W + 1)'(DEPTH);

    state_t      state_q;
    logic        rr_ptr_q;
    logic [3:0]  burst_cnt_q;
    logic        rd_pend_q;
    logic        rd_tag_q;
    logic        rd_oob_q;
    logic [31:0] hold0_q;
    logic [31:0] hold1_q;
    logic        err_oob_q;

    logic              req0, req1;
    logic              own0, own1;
    logic              owner_req, other_req;
    logic              accept, acc_write, acc_read;
    logic              burst_last;
    logic              oob;
    logic [ADDR_W-1:0] sel_address;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wdata;
    logic              sel_read, sel_write;
    logic              rdv0, rdv1;
    logic [31:0]       rdata_src;

    always_comb begin
        req0        = m0.read | m0.write;
        req1        = m1.read | m1.write;
        own0        = (state_q == OWN0);
        own1        = (state_q == OWN1);

        sel_address = own1 ? m1.address    : m0.address;
        sel_be      = own1 ? m1.byteenable : m0.byteenable;
        sel_wdata   = own1 ? m1.writedata  : m0.writedata;
        sel_read    = own1 ? m1.read       : m0.read;
        sel_write   = own1 ? m1.write      : m0.write;

        owner_req   = (own0 & req0) | (own1 & req1);
        other_req   = own1 ? req0 : req1;
        accept      = owner_req;
        // A master asserting both read and write is treated as writing.
        acc_write   = accept & sel_write;
        acc_read    = accept & sel_read & ~sel_write;
        burst_last  = (burst_cnt_q == BURST_LAST);

`ifdef RAM_ARB_BOUNDS_CHECK_EN
        oob         = ({1'b0, sel_address} >= DEPTH_W);
`else
        oob         = 1'b0;
`endif

        ram_address    = sel_address;
        ram_byteenable = sel_be;
        ram_writedata  = sel_wdata;
        ram_chipselect = accept & ~oob;
        ram_write      = acc_write & ~oob;
        ram_clken      = 1'b1;

        m0.waitrequest = ~(own0 & req0);
        m1.waitrequest = ~(own1 & req1);

        rdv0           = rd_pend_q & ~rd_tag_q;
        rdv1           = rd_pend_q &  rd_tag_q;
        rdata_src      = rd_oob_q ? 32'h0 : ram_readdata;

        m0.readdatavalid = rdv0;
        m1.readdatavalid = rdv1;
        m0.readdata      = rdv0 ? rdata_src : hold0_q;
        m1.readdata      = rdv1 ? rdata_src : hold1_q;
    end

`ifdef RAM_ARB_BOUNDS_CHECK_EN
    assign err_oob = err_oob_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= 1'b0;
            burst_cnt_q <= 4'd0;
            rd_pend_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
            rd_oob_q    <= 1'b0;
            hold0_q     <= 32'h0;
            hold1_q     <= 32'h0;
            err_oob_q   <= 1'b0;
        end else begin
            rd_pend_q <= acc_read;
            rd_tag_q  <= own1;
            rd_oob_q  <= acc_read & oob;
            if (rdv0) hold0_q <= rdata_src;
            if (rdv1) hold1_q <= rdata_src;
            if (accept && oob) err_oob_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    burst_cnt_q <= 4'd0;
                    if (req0 && (!req1 || !rr_ptr_q))
                        state_q <= OWN0;
                    else if (req1)
                        state_q <= OWN1;
                end
                default: begin
                    if (!owner_req || (burst_last && other_req)) begin
                        state_q     <= other_req ? (own1 ? OWN0 : OWN1) : IDLE;
                        rr_ptr_q    <= ~own1;
                        burst_cnt_q <= 4'd0;
                    end else if (!burst_last) begin
                        // Saturates while the other master is idle so the cap applies as soon as it requests.
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_qsys_ram_arbiter.sv
// tb/tb_nios2_qsys_ram_arbiter.sv - directed self-checking bench for nios2_qsys_ram_arbiter
`timescale 1ns/1ps
module tb_nios2_qsys_ram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    nios2_qsys_ram_arbiter_if m0_bus ();
    nios2_qsys_ram_arbiter_if m1_bus ();

    logic        rd [2];
    logic        wr [2];
    logic [11:0] addr [2];
    logic [3:0]  be [2];
    logic [31:0] wdata [2];
    logic        waitreq [2];
    logic        rdv [2];
    logic [31:0] rdata [2];

    assign m0_bus.read = rd[0];   assign m0_bus.write = wr[0];
    assign m0_bus.address = addr[0]; assign m0_bus.byteenable = be[0];
    assign m0_bus.writedata = wdata[0];
    assign m1_bus.read = rd[1];   assign m1_bus.write = wr[1];
    assign m1_bus.address = addr[1]; assign m1_bus.byteenable = be[1];
    assign m1_bus.writedata = wdata[1];
    assign waitreq[0] = m0_bus.waitrequest;   assign waitreq[1] = m1_bus.waitrequest;
    assign rdv[0] = m0_bus.readdatavalid;     assign rdv[1] = m1_bus.readdatavalid;
    assign rdata[0] = m0_bus.readdata;        assign rdata[1] = m1_bus.readdata;

    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = 32'h0;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    logic        err_oob;
`endif

    nios2_qsys_ram_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
`ifdef RAM_ARB_BOUNDS_CHECK_EN
        ,
        .err_oob        (err_oob)
`endif
    );

    // Single-port RAM with one-cycle registered read.
    logic [31:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 | i;
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][b*8 +: 8] <= ram_writedata[b*8 +: 8];
            ram_readdata <= mem[ram_address];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          exp_tag_q [$];
    logic [31:0] exp_data_q [$];
    int          exp_cyc_q [$];
    int          grant_q [$];
    logic        cs_at_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Read-return monitor: each readdatavalid must match the oldest outstanding read.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int m = 0; m < 2; m++) begin
                if (rdv[m]) begin
                    if (exp_tag_q.size() == 0) begin
                        check("rdv_unexpected", 32'd1, 32'd0);
                    end else begin
                        check("rdv_tag", m, exp_tag_q.pop_front());
                        check("rdv_data", rdata[m], exp_data_q.pop_front());
                        check("rdv_latency", cyc, exp_cyc_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic xfer(input int m, input bit is_wr, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] bmask, input logic [31:0] exp_rd, output int waits);
        bit done = 0;
        rd[m] = !is_wr; wr[m] = is_wr; addr[m] = a; wdata[m] = d; be[m] = bmask;
        waits = 0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!waitreq[m]) begin
                cs_at_acc = ram_chipselect;
                grant_q.push_back(m);
                if (!is_wr) begin
                    exp_tag_q.push_back(m);
                    exp_data_q.push_back(exp_rd);
                    exp_cyc_q.push_back(cyc + 1);
                end
                @(posedge clk); #1;
                done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int m);
        rd[m] = 1'b0; wr[m] = 1'b0;
    endtask

    task automatic drain(input string tag);
        repeat (3) @(posedge clk);
        #1;
        check(tag, exp_tag_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [19:0] pat;
        int run, max_run;

        reset_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            rd[m] = 1'b1; wr[m] = 1'b0; be[m] = 4'hF; wdata[m] = 32'h0;
        end
        addr[0] = 12'h300; addr[1] = 12'h301;

        repeat (3) begin
            @(negedge clk);
            check("rst_wait0", waitreq[0], 1);
            check("rst_wait1", waitreq[1], 1);
            check("rst_rdv0", rdv[0], 0);
            check("rst_rdv1", rdv[1], 0);
            check("rst_cs", ram_chipselect, 0);
`ifdef RAM_ARB_BOUNDS_CHECK_EN
            check("rst_err_oob", err_oob, 0);
`endif
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_release_own0", 32'(dut.state_q), 1);
        check("rst_release_wait0", waitreq[0], 0);
        check("rst_release_wait1", waitreq[1], 1);
        idle(0); idle(1);
        repeat (2) @(posedge clk);
        #1;

        xfer(0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, w);
        check("sm_wr_wait", w, 1);
        xfer(0, 0, 12'h010, 32'h0, 4'hF, 32'hDEADBEEF, w);
        check("sm_rd_wait", w, 0);
        idle(0);
        drain("sm_drain");

        xfer(0, 1, 12'h020, 32'h11223344, 4'hF, 32'h0, w);
        idle(0);
        xfer(1, 1, 12'h020, 32'hAABBCCDD, 4'b0101, 32'h0, w);
        idle(1);
        xfer(0, 0, 12'h020, 32'h0, 4'hF, 32'h11BB33DD, w);
        idle(0);
        drain("be_drain");

        xfer(1, 0, 12'h030, 32'h0, 4'hF, 32'hC0DE0030, w);
        reset_n = 1'b0;
        exp_tag_q.delete(); exp_data_q.delete(); exp_cyc_q.delete();
        idle(1);
        @(negedge clk);
        check("mr_rdv1", rdv[1], 0);
        check("mr_cs", ram_chipselect, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("mr_state_idle", 32'(dut.state_q), 0);

        grant_q.delete();
        fork
            begin
                for (int k = 0; k < 10; k++)
                    xfer(0, 0, 12'(12'h100 + k), 32'h0, 4'hF, 32'hC0DE0100 + k, w);
                idle(0);
            end
            begin
                int w1;
                for (int k = 0; k < 10; k++)
                    xfer(1, 0, 12'(12'h200 + k), 32'h0, 4'hF, 32'hC0DE0200 + k, w1);
                idle(1);
            end
        join
        drain("ct_drain");
        check("ct_grants", grant_q.size(), 20);
        pat = '0; run = 0; max_run = 0;
        for (int i = 0; i < grant_q.size(); i++) begin
            pat = {pat[18:0], grant_q[i][0]};
            run = (i > 0 && grant_q[i] == grant_q[i-1]) ? run + 1 : 1;
            if (run > max_run) max_run = run;
        end
        check("ct_pattern", pat, 20'h0F0F3);
        check("ct_max_run", max_run, 4);

`ifdef RAM_ARB_BOUNDS_CHECK_EN
        xfer(0, 1, 12'd2560, 32'h5555AAAA, 4'hF, 32'h0, w);
        check("oob_wr_cs", cs_at_acc, 0);
        check("oob_err_after_wr", err_oob, 1);
        xfer(0, 0, 12'd2560, 32'h0, 4'hF, 32'h0, w);
        check("oob_rd_cs", cs_at_acc, 0);
        idle(0);
        drain("oob_drain");
        check("oob_mem_untouched", mem[2560], 32'hC0DE0A00);
        check("oob_err_sticky", err_oob, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
